// File: rtl/ysyx_22051013_mem_arb_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter: data/address widths,
// FSM state encoding and memory size codes.
// Ports: none (package only).
package ysyx_22051013_mem_arb_pkg;

  localparam int XLEN   = 64;
  localparam int STRB_W = XLEN / 8;
  localparam int SIZE_W = 3;

  // Size code driven for instruction fetches (full 8-byte beat).
  localparam logic [SIZE_W-1:0] SIZE_DWORD = 3'b110;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LS_REQ  = 3'd1,
    LS_WAIT = 3'd2,
    IF_REQ  = 3'd3,
    IF_WAIT = 3'd4
  } state_t;

  function automatic logic is_req_state(input state_t s);
    return (s == LS_REQ) || (s == IF_REQ);
  endfunction

endpackage

// File: rtl/ysyx_22051013_starve_cnt.sv
// Saturating up-counter with synchronous clear; tracks consecutive LSU grants
// while a fetch waits. Latency: count visible the cycle after inc/clr.
// Ports: clk, rst (async active-low), inc, clr in; cnt, sat out. No backpressure.
module ysyx_22051013_starve_cnt #(
  parameter int MAX = 4,
  parameter int W   = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  assign sat = (cnt == W'(MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/ysyx_22051013_mem_arb.sv
// Arbitrates one memory port between IFU fetches and LSU loads/stores; LSU has
// priority unless the fetch has waited STARVE_MAX LSU grants.
// Latency: request on mem_* one cycle after selection; response strobe and rdata
// one cycle after mem_rvalid. Backpressure: one transaction in flight; requesters
// hold their request until the response strobe, mem_gnt stalls in *_REQ.
// Ports: clk, rst (async active-low); IFU if_*; LSU ls_*; memory mem_*; busy.
module ysyx_22051013_mem_arb
  import ysyx_22051013_mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  // IFU side
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  output logic [XLEN-1:0]   if_rdata,
  output logic              if_valid,
  // LSU side
  input  logic              ls_re,
  input  logic              ls_we,
  input  logic [XLEN-1:0]   ls_addr,
  input  logic [XLEN-1:0]   ls_wdata,
  input  logic [STRB_W-1:0] ls_wstrb,
  input  logic [SIZE_W-1:0] ls_size,
  output logic [XLEN-1:0]   ls_rdata,
  output logic              ls_valid,
  // memory side
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [SIZE_W-1:0] mem_size,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              busy
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  state_t state, state_nxt;

  logic              ls_pick, if_pick;
  logic              starve_sat;
  logic [CNT_W-1:0]  starve_cnt;

  logic              cap_we;
  logic [XLEN-1:0]   cap_addr;
  logic [XLEN-1:0]   cap_wdata;
  logic [STRB_W-1:0] cap_wstrb;
  logic [SIZE_W-1:0] cap_size;

  // Selection happens only in IDLE. A pending fetch that has already seen
  // STARVE_MAX consecutive LSU grants wins over the LSU.
  assign ls_pick = (state == IDLE) && (ls_re || ls_we) && !(if_req && starve_sat);
  assign if_pick = (state == IDLE) && !ls_pick && if_req;

  ysyx_22051013_starve_cnt #(
    .MAX (STARVE_MAX),
    .W   (CNT_W)
  ) u_starve_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ls_pick && if_req),
    .clr (if_pick || !if_req),
    .cnt (starve_cnt),
    .sat (starve_sat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ls_pick) begin
          state_nxt = LS_REQ;
        end else if (if_pick) begin
          state_nxt = IF_REQ;
        end
      end
      LS_REQ:  if (mem_gnt)    state_nxt = LS_WAIT;
      LS_WAIT: if (mem_rvalid) state_nxt = IDLE;
      IF_REQ:  if (mem_gnt)    state_nxt = IF_WAIT;
      IF_WAIT: if (mem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request attributes are frozen at selection so the requester may change its
  // inputs while the transaction is in flight. Reads carry zero data/strobes;
  // re+we together is treated as a store.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_wstrb <= '0;
      cap_size  <= '0;
    end else if (ls_pick) begin
      cap_we    <= ls_we;
      cap_addr  <= ls_addr;
      cap_wdata <= ls_we ? ls_wdata : '0;
      cap_wstrb <= ls_we ? ls_wstrb : '0;
      cap_size  <= ls_size;
    end else if (if_pick) begin
      cap_we    <= 1'b0;
      cap_addr  <= if_addr;
      cap_wdata <= '0;
      cap_wstrb <= '0;
      cap_size  <= SIZE_DWORD;
    end
  end

  // Response strobes are registered; the strobe cycle is therefore always an
  // IDLE cycle, so back-to-back transactions are separated by at least one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_valid <= 1'b0;
      ls_valid <= 1'b0;
      if_rdata <= '0;
      ls_rdata <= '0;
    end else begin
      if_valid <= (state == IF_WAIT) && mem_rvalid;
      ls_valid <= (state == LS_WAIT) && mem_rvalid;
      if ((state == IF_WAIT) && mem_rvalid) begin
        if_rdata <= mem_rdata;
      end
      // A store ack must not disturb the last load data.
      if ((state == LS_WAIT) && mem_rvalid && !cap_we) begin
        ls_rdata <= mem_rdata;
      end
    end
  end

  assign mem_req   = is_req_state(state);
  assign mem_we    = (state == LS_REQ) && cap_we;
  assign mem_addr  = cap_addr;
  assign mem_wdata = cap_wdata;
  assign mem_wstrb = cap_wstrb;
  assign mem_size  = cap_size;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ysyx_22051013_mem_arb.sv
// Directed bench for ysyx_22051013_mem_arb: bench plays the memory, drives
// requests on the falling edge and samples outputs there.
// Ports: none (top-level bench).
module tb_ysyx_22051013_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic [63:0] if_rdata;
  logic        if_valid;
  logic        ls_re, ls_we;
  logic [63:0] ls_addr, ls_wdata;
  logic [7:0]  ls_wstrb;
  logic [2:0]  ls_size;
  logic [63:0] ls_rdata;
  logic        ls_valid;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wstrb;
  logic [2:0]  mem_size;
  logic        mem_gnt, mem_rvalid;
  logic [63:0] mem_rdata;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // values observed by serve()
  logic [63:0] obs_addr, obs_wdata, obs_wait_addr;
  logic [7:0]  obs_wstrb;
  logic [2:0]  obs_size;
  logic        obs_we, obs_req_after, obs_lsv, obs_ifv, obs_busy;
  logic        poke_en = 1'b0;
  logic [63:0] exp_ls_rdata;

  always #5 clk = ~clk;

  ysyx_22051013_mem_arb #(.STARVE_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_valid   (if_valid),
    .ls_re      (ls_re),
    .ls_we      (ls_we),
    .ls_addr    (ls_addr),
    .ls_wdata   (ls_wdata),
    .ls_wstrb   (ls_wstrb),
    .ls_size    (ls_size),
    .ls_rdata   (ls_rdata),
    .ls_valid   (ls_valid),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_size   (mem_size),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Wait for mem_req, record request fields, grant after gd cycles, answer
  // after rd cycles, then record the response-cycle outputs.
  task automatic serve(input int gd, input int rd, input logic [63:0] data);
    int n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!mem_req) begin
      chk("req_timeout", 64'(mem_req), 64'd1);
      return;
    end
    obs_addr  = mem_addr;
    obs_we    = mem_we;
    obs_wdata = mem_wdata;
    obs_wstrb = mem_wstrb;
    obs_size  = mem_size;
    repeat (gd) @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    obs_req_after = mem_req;
    if (poke_en) ls_addr = 64'h0;
    repeat (rd) @(negedge clk);
    obs_wait_addr = mem_addr;
    mem_rdata  = data;
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    obs_lsv  = ls_valid;
    obs_ifv  = if_valid;
    obs_busy = busy;
  endtask

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_re = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0; ls_size = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // reset state
    @(negedge clk);
    chk("rst_busy",     64'(busy),     64'd0);
    chk("rst_mem_req",  64'(mem_req),  64'd0);
    chk("rst_mem_we",   64'(mem_we),   64'd0);
    chk("rst_ls_valid", 64'(ls_valid), 64'd0);
    chk("rst_if_valid", 64'(if_valid), 64'd0);
    chk("rst_ls_rdata", ls_rdata,      64'd0);
    chk("rst_if_rdata", if_rdata,      64'd0);
    rst = 1'b1;
    @(negedge clk);

    // stray gnt/rvalid in IDLE are ignored
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hCAFE_F00D_0000_0001;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk("idle_rv_lsv",   64'(ls_valid), 64'd0);
    chk("idle_rv_ifv",   64'(if_valid), 64'd0);
    chk("idle_gnt_busy", 64'(busy),     64'd0);
    chk("idle_rv_rdata", ls_rdata,      64'd0);

    // request pulse that vanishes before the clock edge
    ls_re = 1'b1;
    #2 ls_re = 1'b0;
    @(negedge clk);
    chk("pulse_req",  64'(mem_req), 64'd0);
    @(negedge clk);
    chk("pulse_busy", 64'(busy),    64'd0);

    // LSU read
    ls_re = 1'b1; ls_addr = 64'h8000_0008; ls_size = 3'b011;
    ls_wdata = 64'hAAAA_AAAA_AAAA_AAAA; ls_wstrb = 8'hFF;
    serve(2, 3, 64'h1122_3344_5566_7788);
    ls_re = 1'b0;
    chk("rd_addr",      obs_addr,             64'h8000_0008);
    chk("rd_we",        64'(obs_we),          64'd0);
    chk("rd_wdata",     obs_wdata,            64'd0);
    chk("rd_wstrb",     64'(obs_wstrb),       64'd0);
    chk("rd_size",      64'(obs_size),        64'd3);
    chk("rd_req_fall",  64'(obs_req_after),   64'd0);
    chk("rd_lsv",       64'(obs_lsv),         64'd1);
    chk("rd_ifv",       64'(obs_ifv),         64'd0);
    chk("rd_busy",      64'(obs_busy),        64'd0);
    chk("rd_rdata",     ls_rdata,             64'h1122_3344_5566_7788);
    @(negedge clk);
    chk("rd_lsv_1cyc",  64'(ls_valid),        64'd0);
    chk("rd_ifv_never", 64'(if_valid),        64'd0);

    // simultaneous IFU + LSU: LSU first, then IFU
    ls_re = 1'b1; ls_addr = 64'h8000_0100; ls_size = 3'b010;
    if_req = 1'b1; if_addr = 64'h8000_2000;
    serve(0, 1, 64'h0000_0000_ABCD_0001);
    ls_re = 1'b0;
    chk("sim1_addr", obs_addr,     64'h8000_0100);
    chk("sim1_size", 64'(obs_size), 64'd2);
    chk("sim1_lsv",  64'(obs_lsv),  64'd1);
    chk("sim1_ifv",  64'(obs_ifv),  64'd0);
    serve(1, 0, 64'h1357_9BDF_0246_8ACE);
    if_req = 1'b0;
    chk("sim2_addr",  obs_addr,       64'h8000_2000);
    chk("sim2_size",  64'(obs_size),  64'd6);
    chk("sim2_we",    64'(obs_we),    64'd0);
    chk("sim2_wstrb", 64'(obs_wstrb), 64'd0);
    chk("sim2_ifv",   64'(obs_ifv),   64'd1);
    chk("sim2_lsv",   64'(obs_lsv),   64'd0);
    chk("sim2_ifrd",  if_rdata,       64'h1357_9BDF_0246_8ACE);
    chk("sim2_lsrd",  ls_rdata,       64'h0000_0000_ABCD_0001);
    @(negedge clk);

    // starvation: four LSU grants, then the fetch
    ls_re = 1'b1; ls_addr = 64'h8000_0040; ls_size = 3'b011;
    if_req = 1'b1; if_addr = 64'h8000_3000;
    for (int i = 0; i < 5; i++) begin
      serve(0, 0, 64'h5000 + 64'(i));
      chk($sformatf("starve%0d_lsv", i), 64'(obs_lsv), (i < 4) ? 64'd1 : 64'd0);
      chk($sformatf("starve%0d_ifv", i), 64'(obs_ifv), (i < 4) ? 64'd0 : 64'd1);
    end
    ls_re = 1'b0; if_req = 1'b0;
    chk("starve_if_size", 64'(obs_size), 64'd6);
    chk("starve_ls_rd",   ls_rdata,      64'h5003);
    chk("starve_if_rd",   if_rdata,      64'h5004);
    exp_ls_rdata = 64'h5003;
    @(negedge clk);

    // store with re and we both high
    ls_re = 1'b1; ls_we = 1'b1; ls_addr = 64'h8000_1000; ls_size = 3'b010;
    ls_wstrb = 8'h0F; ls_wdata = 64'h0000_0000_DEAD_BEEF;
    serve(1, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    ls_re = 1'b0; ls_we = 1'b0;
    chk("wr_we",    64'(obs_we),    64'd1);
    chk("wr_wstrb", 64'(obs_wstrb), 64'h0F);
    chk("wr_wdata", obs_wdata,      64'h0000_0000_DEAD_BEEF);
    chk("wr_lsv",   64'(obs_lsv),   64'd1);
    chk("wr_rdata", ls_rdata,       exp_ls_rdata);
    @(negedge clk);

    // address change while waiting does not leak into the transaction
    ls_re = 1'b1; ls_addr = 64'h8000_0008; ls_size = 3'b011; poke_en = 1'b1;
    serve(0, 2, 64'h0F0F_0F0F_0F0F_0F0F);
    ls_re = 1'b0; poke_en = 1'b0;
    chk("hold_addr",  obs_wait_addr, 64'h8000_0008);
    chk("hold_rdata", ls_rdata,      64'h0F0F_0F0F_0F0F_0F0F);
    @(negedge clk);

    // reset during IF_WAIT abandons the fetch
    if_req = 1'b1; if_addr = 64'h8000_4000;
    @(negedge clk);
    chk("rw_req", 64'(mem_req), 64'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; if_req = 1'b0;
    chk("rw_busy_wait", 64'(busy), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rw_async_busy",  64'(busy), 64'd0);
    chk("rw_async_ifrd",  if_rdata,  64'd0);
    @(negedge clk);
    rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h7777_7777_7777_7777;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("rw_ifv",   64'(if_valid), 64'd0);
    chk("rw_busy",  64'(busy),     64'd0);
    chk("rw_ifrd",  if_rdata,      64'd0);
    chk("rw_lsrd",  ls_rdata,      64'd0);
    @(negedge clk);
    chk("rw_ifv2",  64'(if_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22051013_mem_arb.md
YSYX_22051013_MEM_ARB -- requirements
Module: ysyx_22051013_mem_arb

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: maximum consecutive LSU grants while an IFU request is pending.
REQ-002 SHALL have ports: clk  in  1  single clock, all state on posedge.
REQ-003 SHALL have ports: rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have IFU side: if_req in 1 fetch request; if_addr in 64 fetch address; if_rdata out 64 fetch data; if_valid out 1 one-cycle response strobe.
REQ-005 SHALL have LSU side: ls_re in 1; ls_we in 1; ls_addr in 64; ls_wdata in 64; ls_wstrb in 8 byte strobe; ls_size in 3; ls_rdata out 64; ls_valid out 1 one-cycle response strobe.
REQ-006 SHALL have memory side: mem_req out 1; mem_we out 1; mem_addr out 64; mem_wdata out 64; mem_wstrb out 8; mem_size out 3; mem_gnt in 1 request accepted; mem_rvalid in 1 response (read data or write ack); mem_rdata in 64.
REQ-007 SHALL drive busy out 1, high in every state except IDLE.

Function
REQ-008 SHALL implement FSM states IDLE, LS_REQ, LS_WAIT, IF_REQ, IF_WAIT.
REQ-009 IDLE: ls_re|ls_we -> LS_REQ unless starvation rule applies; else if_req -> IF_REQ; else stay.
REQ-010 Starvation: counter incremented on each LSU grant while if_req high, cleared on IFU grant or when if_req low; at STARVE_MAX with if_req high, IDLE SHALL select IF_REQ.
REQ-011 On entering a *_REQ state, request attributes SHALL be captured into registers; later requester input changes SHALL NOT affect the transaction in flight.
REQ-012 ls_re and ls_we both high SHALL be issued as a write (mem_we=1).
REQ-013 In *_REQ: mem_req=1 with captured fields; mem_gnt=1 -> matching *_WAIT next cycle; mem_req SHALL fall the cycle after grant.
REQ-014 In *_WAIT: mem_rvalid=1 -> assert the owner's valid for exactly one cycle, load owner's rdata from mem_rdata, return to IDLE.
REQ-015 A new grant SHALL NOT occur in the cycle a response is delivered (minimum one IDLE cycle between transactions).
REQ-016 if_rdata and ls_rdata SHALL hold their last value until the next response to that requester; LSU writes SHALL NOT update ls_rdata.
REQ-017 mem_rvalid in IDLE or *_REQ SHALL be ignored; mem_gnt outside *_REQ SHALL be ignored.
REQ-018 A request deasserted before entering *_REQ SHALL produce no memory transaction.
REQ-019 mem_wdata/mem_wstrb SHALL be zero for reads; mem_size SHALL carry ls_size for LSU, 3'b110 (8 bytes) for IFU.
REQ-020 Outputs other than rdata registers SHALL be decoded from state and captured registers only (no combinational input-to-output path).

Reset
REQ-021 rst low SHALL asynchronously force IDLE, clear counter, capture registers, both rdata to 0, all valid/mem_req/mem_we/busy to 0.
REQ-022 Reset mid-transaction SHALL abandon it; no response strobe SHALL follow.

Structure
REQ-023 State encoding, mem_size codes, and the 64-bit data/address width macros SHALL live in the shared define file.
REQ-024 A single sub-module ysyx_22051013_starve_cnt (saturating counter with clear) is natural; all else flat.

Verification
REQ-025 LSU read only: ls_re=1, ls_addr=0x80000008, gnt after 2 cycles, rvalid with 0x1122334455667788 after 3 -> ls_valid one cycle, ls_rdata=0x1122334455667788, if_valid never.
REQ-026 Simultaneous if_req and ls_re in IDLE -> LSU granted first, IFU next, mem_size 3'b110 for IFU.
REQ-027 Continuous LSU requests with if_req held, STARVE_MAX=4 -> 4 LSU transactions then one IFU transaction.
REQ-028 ls_re=ls_we=1, ls_wstrb=0x0F, ls_wdata=0xDEADBEEF -> mem_we=1, mem_wstrb=0x0F; ls_valid on ack; ls_rdata unchanged.
REQ-029 ls_addr changed to 0x0 during LS_WAIT -> mem_addr stays 0x80000008 until completion.
REQ-030 rst low during IF_WAIT, then mem_rvalid=1 -> busy=0, if_valid stays 0, if_rdata=0.
